// File: rtl/ysyx_23060278_pc_gen_if.sv
// Fetch-PC generator bundle: redirect requests from EXU/CSR in, IFU handshake and status out.
interface ysyx_23060278_pc_gen_if #(
    parameter int XLEN = 32
);
    logic            pc_ready;
    logic            trap_en;
    logic [XLEN-1:0] trap_vec;
    logic            mret_en;
    logic [XLEN-1:0] mepc;
    logic            jalr_en;
    logic            jal_en;
    logic            br_taken;
    logic [XLEN-1:0] target;
    logic            halt_req;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [XLEN-1:0] snxt_pc;
    logic            flush;
    logic            misalign;
    logic [XLEN-1:0] misalign_addr;
    logic            halted;

    modport master (
        output pc_ready, trap_en, trap_vec, mret_en, mepc,
               jalr_en, jal_en, br_taken, target, halt_req,
        input  pc, pc_valid, snxt_pc, flush, misalign, misalign_addr, halted
    );

    modport slave (
        input  pc_ready, trap_en, trap_vec, mret_en, mepc,
               jalr_en, jal_en, br_taken, target, halt_req,
        output pc, pc_valid, snxt_pc, flush, misalign, misalign_addr, halted
    );
endinterface

// File: rtl/ysyx_23060278_pc_gen.sv
// Fetch-PC generator: boot delay, prioritised redirects, misaligned-target rejection, halt.
//
// state  | meaning
// S_BOOT | waiting BOOT_CYCLES after reset, pc held, no fetch offered
// S_RUN  | pc offered to IFU, redirects and sequential advance applied
// S_HALT | frozen until reset
module ysyx_23060278_pc_gen #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
    parameter int              STEP        = 4,
    parameter int              BOOT_CYCLES = 2
) (
    input logic                     clk,
    input logic                     rst,
    ysyx_23060278_pc_gen_if.slave   s_if
);
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [7:0]      BOOT_LAST = 8'(BOOT_CYCLES - 1);
    localparam logic [XLEN-1:0] STEP_W    = XLEN'(STEP);

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [7:0]      r_boot_cnt, w_boot_cnt_nxt;
    logic            r_flush, w_flush_nxt;
    logic            r_misalign, w_misalign_nxt;
    logic [XLEN-1:0] r_misalign_addr, w_misalign_addr_nxt;

    logic [XLEN-1:0] w_snxt_pc;
    logic [XLEN-1:0] w_tgt;
    logic            w_redir;
    logic            w_chk_align;

    assign w_snxt_pc = r_pc + STEP_W;

    // Redirect source selection; only ALU-computed targets are alignment-checked.
    always_comb begin
        w_tgt       = '0;
        w_redir     = 1'b0;
        w_chk_align = 1'b0;
        if (s_if.trap_en) begin
            w_tgt   = {s_if.trap_vec[XLEN-1:2], 2'b00};
            w_redir = 1'b1;
        end else if (s_if.mret_en) begin
            w_tgt   = {s_if.mepc[XLEN-1:2], 2'b00};
            w_redir = 1'b1;
        end else if (s_if.jalr_en) begin
            w_tgt       = {s_if.target[XLEN-1:1], 1'b0};
            w_redir     = 1'b1;
            w_chk_align = 1'b1;
        end else if (s_if.jal_en || s_if.br_taken) begin
            w_tgt       = s_if.target;
            w_redir     = 1'b1;
            w_chk_align = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_boot_cnt_nxt      = r_boot_cnt;
        w_flush_nxt         = 1'b0;
        w_misalign_nxt      = 1'b0;
        w_misalign_addr_nxt = r_misalign_addr;
        case (r_state)
            S_BOOT: begin
                w_boot_cnt_nxt = r_boot_cnt + 8'd1;
                if (r_boot_cnt == BOOT_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (s_if.halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (w_redir) begin
                    if (w_chk_align && (w_tgt[1:0] != 2'b00)) begin
                        w_misalign_nxt      = 1'b1;
                        w_misalign_addr_nxt = w_tgt;
                    end else begin
                        w_pc_nxt    = w_tgt;
                        w_flush_nxt = 1'b1;
                    end
                end else if (s_if.pc_ready) begin
                    w_pc_nxt = w_snxt_pc;
                end
            end
            S_HALT: begin
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_BOOT;
            r_pc            <= RESET_PC;
            r_boot_cnt      <= 8'd0;
            r_flush         <= 1'b0;
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_boot_cnt      <= w_boot_cnt_nxt;
            r_flush         <= w_flush_nxt;
            r_misalign      <= w_misalign_nxt;
            r_misalign_addr <= w_misalign_addr_nxt;
        end
    end

    assign s_if.pc            = r_pc;
    assign s_if.pc_valid      = (r_state == S_RUN);
    assign s_if.snxt_pc       = w_snxt_pc;
    assign s_if.flush         = r_flush;
    assign s_if.misalign      = r_misalign;
    assign s_if.misalign_addr = r_misalign_addr;
    assign s_if.halted        = (r_state == S_HALT);
endmodule
